// File: rtl/tt_um_ternary_mac.sv
// Ternary-weight matrix-vector MAC: streams activations, accumulates
// per-output sums, then streams saturated 8-bit results.
module tt_um_ternary_mac #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int ACC_WIDTH   = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  ui_weights,
  input  logic [6:0]                           ui_param,
  input  logic                                 ui_start,
  input  logic [7:0]                           ui_act,
  input  logic                                 ui_act_valid,
  output logic                                 uo_act_ready,
  output logic [7:0]                           uo_out,
  output logic                                 uo_out_valid,
  input  logic                                 ui_out_ready,
  output logic                                 uo_busy,
  output logic                                 uo_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT,
    S_DONE
  } state_e;

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-128);

  state_e state_q, state_d;

  logic [3:0] in_len_q, in_len_d;
  logic [3:0] i_q, i_d;
  logic [2:0] out_len_q, out_len_d;
  logic [2:0] j_q, j_d;

  logic signed [ACC_WIDTH-1:0] acc_q [MAX_OUT_LEN];
  logic signed [ACC_WIDTH-1:0] acc_d [MAX_OUT_LEN];
  logic signed [ACC_WIDTH-1:0] act_ext;
  logic signed [ACC_WIDTH-1:0] acc_sel;

  always_comb begin
    state_d   = state_q;
    in_len_d  = in_len_q;
    out_len_d = out_len_q;
    i_d       = i_q;
    j_d       = j_q;
    for (int k = 0; k < MAX_OUT_LEN; k++) begin
      acc_d[k] = acc_q[k];
    end
    act_ext = {{(ACC_WIDTH-8){ui_act[7]}}, ui_act};

    unique case (state_q)
      S_IDLE: begin
        if (ui_start) begin
          in_len_d  = ui_param[6:3];
          out_len_d = ui_param[2:0];
          i_d       = '0;
          j_d       = '0;
          for (int k = 0; k < MAX_OUT_LEN; k++) begin
            acc_d[k] = '0;
          end
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (ui_act_valid) begin
          // Unused output columns stay at zero
          for (int k = 0; k < MAX_OUT_LEN; k++) begin
            if (k <= int'(out_len_q)) begin
              case (ui_weights[2*(int'(i_q)*MAX_OUT_LEN+k) +: 2])
                2'b01:   acc_d[k] = acc_q[k] + act_ext;
                2'b11:   acc_d[k] = acc_q[k] - act_ext;
                default: acc_d[k] = acc_q[k];
              endcase
            end
          end
          i_d = i_q + 4'd1;
          if (i_q == in_len_q) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (ui_out_ready) begin
          j_d = j_q + 3'd1;
          if (j_q == out_len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    acc_sel      = acc_q[j_q];
    uo_out       = 8'h00;
    uo_act_ready = (state_q == S_ACC);
    uo_out_valid = (state_q == S_OUT);
    uo_busy      = (state_q != S_IDLE);
    uo_done      = (state_q == S_DONE);
    if (state_q == S_OUT) begin
      if (acc_sel > SAT_HI) begin
        uo_out = 8'h7f;
      end else if (acc_sel < SAT_LO) begin
        uo_out = 8'h80;
      end else begin
        uo_out = acc_sel[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_len_q  <= '0;
      out_len_q <= '0;
      i_q       <= '0;
      j_q       <= '0;
      for (int k = 0; k < MAX_OUT_LEN; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      in_len_q  <= in_len_d;
      out_len_q <= out_len_d;
      i_q       <= i_d;
      j_q       <= j_d;
      for (int k = 0; k < MAX_OUT_LEN; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

endmodule

// File: tb/tb_tt_um_ternary_mac.sv
// Directed bench for tt_um_ternary_mac: small run, saturation,
// reserved codes with gaps, backpressure and mid-run reset.
module tb_tt_um_ternary_mac;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] ui_weights;
  logic [6:0]   ui_param;
  logic         ui_start;
  logic [7:0]   ui_act;
  logic         ui_act_valid;
  logic         uo_act_ready;
  logic [7:0]   uo_out;
  logic         uo_out_valid;
  logic         ui_out_ready;
  logic         uo_busy;
  logic         uo_done;

  tt_um_ternary_mac dut (
    .clk          (clk),
    .rst          (rst),
    .ui_weights   (ui_weights),
    .ui_param     (ui_param),
    .ui_start     (ui_start),
    .ui_act       (ui_act),
    .ui_act_valid (ui_act_valid),
    .uo_act_ready (uo_act_ready),
    .uo_out       (uo_out),
    .uo_out_valid (uo_out_valid),
    .ui_out_ready (ui_out_ready),
    .uo_busy      (uo_busy),
    .uo_done      (uo_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic signed [7:0] acts [16];
  int exp_out [8];
  int gap;
  int stall_j;
  int stall_n;
  int keep_start;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic setw(input int i, input int j, input logic [1:0] c);
    ui_weights[2*(i*8+j) +: 2] = c;
  endtask

  task automatic fillw(input logic [1:0] c);
    for (int k = 0; k < 128; k++) ui_weights[2*k +: 2] = c;
  endtask

  task automatic run(input string tag, input logic [6:0] p,
                     input int n_in, input int n_out,
                     input int exp_acc, input int exp_cyc);
    int cyc;
    int accc;
    cyc  = 1;
    accc = 0;
    ui_param = p;
    ui_start = 1'b1;
    @(negedge clk); cyc++;
    ui_param = 7'h00;
    if (keep_start == 0) ui_start = 1'b0;
    for (int idx = 0; idx < n_in; idx++) begin
      if (gap != 0) begin
        ui_act_valid = 1'b0;
        ui_act = 8'd100;
        accc += int'(uo_act_ready);
        @(negedge clk); cyc++;
      end
      ui_act_valid = 1'b1;
      ui_act = acts[idx];
      accc += int'(uo_act_ready);
      @(negedge clk); cyc++;
    end
    ui_act_valid = 1'b0;
    ui_start = 1'b0;
    chk({tag, " acc_cycles"}, accc, exp_acc);
    chk({tag, " ready_drop"}, int'(uo_act_ready), 0);
    for (int jj = 0; jj < n_out; jj++) begin
      if (jj == stall_j) begin
        ui_out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk({tag, " stall_valid"}, int'(uo_out_valid), 1);
          chk({tag, " stall_out"}, int'($signed(uo_out)), exp_out[jj]);
          @(negedge clk); cyc++;
        end
      end
      ui_out_ready = 1'b1;
      chk({tag, " valid"}, int'(uo_out_valid), 1);
      chk({tag, $sformatf(" out%0d", jj)}, int'($signed(uo_out)), exp_out[jj]);
      @(negedge clk); cyc++;
    end
    ui_out_ready = 1'b0;
    chk({tag, " done"}, int'(uo_done), 1);
    chk({tag, " latency"}, cyc, exp_cyc);
    @(negedge clk);
    chk({tag, " done_pulse"}, int'(uo_done), 0);
    chk({tag, " idle"}, int'(uo_busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    ui_weights = '0;
    ui_param = '0;
    ui_start = 1'b0;
    ui_act = '0;
    ui_act_valid = 1'b0;
    ui_out_ready = 1'b0;
    gap = 0;
    stall_j = -1;
    stall_n = 0;
    keep_start = 0;
    @(negedge clk);
    chk("rst act_ready", int'(uo_act_ready), 0);
    chk("rst out_valid", int'(uo_out_valid), 0);
    chk("rst out", int'(uo_out), 0);
    chk("rst busy", int'(uo_busy), 0);
    chk("rst done", int'(uo_done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Small run: 5 - 3 = 2
    setw(0, 0, 2'b01);
    setw(1, 0, 2'b11);
    acts[0] = 8'sd5;
    acts[1] = 8'sd3;
    exp_out[0] = 2;
    run("small", 7'b0001_000, 2, 1, 2, 5);

    // Saturation high: 16*10 = 160 -> 127
    fillw(2'b01);
    for (int k = 0; k < 16; k++) acts[k] = 8'sd10;
    for (int k = 0; k < 8; k++) exp_out[k] = 127;
    run("sat_hi", 7'h7F, 16, 8, 16, 26);

    // Saturation low: -160 -> -128
    fillw(2'b11);
    for (int k = 0; k < 8; k++) exp_out[k] = -128;
    run("sat_lo", 7'h7F, 16, 8, 16, 26);

    // Reserved code with gaps between activations
    fillw(2'b10);
    for (int k = 0; k < 16; k++) acts[k] = 8'sd100;
    for (int k = 0; k < 8; k++) exp_out[k] = 0;
    gap = 1;
    run("gaps", 7'b0011_011, 4, 4, 8, 14);
    gap = 0;

    // Backpressure with distinct per-column results
    fillw(2'b00);
    setw(0, 0, 2'b01);
    setw(1, 1, 2'b01);
    setw(0, 2, 2'b01);
    setw(1, 2, 2'b11);
    setw(0, 3, 2'b11);
    setw(1, 3, 2'b11);
    acts[0] = 8'sd3;
    acts[1] = 8'sd5;
    exp_out[0] = 3;
    exp_out[1] = 5;
    exp_out[2] = -2;
    exp_out[3] = -8;
    stall_j = 1;
    stall_n = 3;
    run("bp", 7'b0001_011, 2, 4, 2, 11);
    stall_j = -1;

    // Mid-ACC reset after four activations
    fillw(2'b01);
    ui_param = 7'h7F;
    ui_start = 1'b1;
    @(negedge clk);
    ui_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ui_act_valid = 1'b1;
      ui_act = 8'sd50;
      @(negedge clk);
    end
    ui_act_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", int'(uo_busy), 0);
    chk("abort ready", int'(uo_act_ready), 0);
    chk("abort valid", int'(uo_out_valid), 0);
    @(negedge clk);
    chk("abort no_done", int'(uo_done), 0);
    chk("abort idle", int'(uo_busy), 0);

    // Fresh run with start held high: no stale sum, start ignored
    fillw(2'b00);
    setw(0, 0, 2'b01);
    acts[0] = -8'sd7;
    exp_out[0] = -7;
    keep_start = 1;
    run("post_rst", 7'b0000_000, 1, 1, 1, 4);
    keep_start = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
